// File: rtl/adder_result_fifo_if.sv
// Handshake bundle between an adder result producer, the result FIFO and its consumer.
// Entry width grows by one parity bit when ADDER_RESULT_PARITY_EN is defined.
interface adder_result_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;
`ifdef ADDER_RESULT_PARITY_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH + 1;
`endif

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] cout_cnt;
    logic             cnt_clr;
    logic             ovf;

    modport master (
        output in_valid, sum, cout, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, level, cout_cnt, ovf
    );

    modport slave (
        input  in_valid, sum, cout, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, level, cout_cnt, ovf
    );
endinterface

// File: rtl/adder_result_fifo.sv
// Small FIFO buffering {cout,sum} adder results, with a carry-out event counter and sticky overflow.
// Optional feature: define ADDER_RESULT_PARITY_EN to store an even-parity bit as the entry MSB.
module adder_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    adder_result_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef ADDER_RESULT_PARITY_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH + 1;
`endif

    logic [DW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [DW-1:0]    head_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             push;
    logic             pop;
    logic [DW-1:0]    din;
    logic [PW-1:0]    next_rd;
    logic [LW-1:0]    next_level;

`ifdef ADDER_RESULT_PARITY_EN
    assign din = {^{bus.cout, bus.sum}, bus.cout, bus.sum};
`else
    assign din = {bus.cout, bus.sum};
`endif

    // Handshake flags come straight from the level register, so there is no path from out_ready or sum.
    assign bus.in_ready  = (level_q != LW'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = head_q;
    assign bus.level     = level_q;
    assign bus.cout_cnt  = cnt_q;
    assign bus.ovf       = ovf_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_rd    = rd_ptr;
        next_level = level_q + LW'(push) - LW'(pop);
        if (pop) next_rd = rd_ptr + PW'(1);
    end

    // NOTE: storage is deliberately not reset; head_q carries the reset-visible value instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr  <= next_rd;
            level_q <= next_level;

            // Head register preloads the next entry; the slot being written this edge must come from din.
            if (next_level != '0) begin
                if (push && (wr_ptr == next_rd)) head_q <= din;
                else                             head_q <= mem[next_rd];
            end

            if (bus.cnt_clr)
                cnt_q <= '0;
            else if (push && bus.cout && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);

            if (bus.in_valid && !bus.in_ready) ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo with a queue scoreboard modelling contents, level, counter and ovf.
// Honours ADDER_RESULT_PARITY_EN the same way the design does.
module tb_adder_result_fifo;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ADDER_RESULT_PARITY_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned   n_cmp = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] mdl_last = '0;
    logic          mdl_ovf  = 1'b0;
    int            mdl_cnt  = 0;

    function automatic logic [DW-1:0] ent(input logic [WIDTH-1:0] s, input logic c);
`ifdef ADDER_RESULT_PARITY_EN
        return {^{c, s}, c, s};
`else
        return {c, s};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_data;
        exp_data = (mdl_q.size() > 0) ? mdl_q[0] : mdl_last;
        check({tag, ".level"},     32'(bus.level),     32'(mdl_q.size()));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(mdl_q.size() < DEPTH));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mdl_q.size() > 0));
        check({tag, ".out_data"},  32'(bus.out_data),  32'(exp_data));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(mdl_ovf));
        check({tag, ".cout_cnt"},  32'(bus.cout_cnt),  32'(mdl_cnt));
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_last = '0;
        mdl_ovf  = 1'b0;
        mdl_cnt  = 0;
    endtask

    // One clock: drive inputs, step the model with pre-edge state, compare just after the edge.
    task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] s,
                         input logic c, input logic ordy, input logic clr);
        logic acc;
        logic pp;
        bus.in_valid  = iv;
        bus.sum       = s;
        bus.cout      = c;
        bus.out_ready = ordy;
        bus.cnt_clr   = clr;
        acc = iv && (mdl_q.size() < DEPTH);
        pp  = ordy && (mdl_q.size() > 0);
        @(posedge clk);
        #1;
        if (pp) mdl_last = mdl_q.pop_front();
        if (acc) mdl_q.push_back(ent(s, c));
        if (iv && !acc) mdl_ovf = 1'b1;
        if (clr) mdl_cnt = 0;
        else if (acc && c && mdl_cnt < CNT_MAX) mdl_cnt++;
        check_outputs(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.cout      = 1'b0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;

        // Reset state, visible before any clock edge.
        #1;
        check_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;

        // Single push becomes visible right after its edge.
        cycle("push1111", 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        check("push1111.lit_level", 32'(bus.level), 32'd1);
        cycle("pop1111", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Full-carry adder results keep order and bump the carry counter.
        cycle("ffff_c0", 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        cycle("ffff_c1", 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check("ffff.head", 32'(bus.out_data), 32'(ent(16'hFFFE, 1'b1)));
        cycle("pop_fffe", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ffff.second", 32'(bus.out_data), 32'(ent(16'hFFFF, 1'b1)));
        cycle("pop_ffff", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("ffff.cnt", 32'(bus.cout_cnt), 32'd2);

        // Popping while empty is ignored and the last head value stays on out_data.
        cycle("empty_pop", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("empty_hold", 32'(bus.out_data), 32'(ent(16'hFFFF, 1'b1)));

        // Fill past capacity: fifth beat dropped, ovf sticks, contents survive.
        for (int i = 0; i < 5; i++)
            cycle("fill", 1'b1, 16'(16'hA000 + i), 1'(i & 1), 1'b0, 1'b0);
        check("fill.ovf", 32'(bus.ovf), 32'd1);
        check("fill.level", 32'(bus.level), 32'(DEPTH));
        cycle("full_pushpop", 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle("drain", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("drain.ovf_sticky", 32'(bus.ovf), 32'd1);

        // Steady-state push+pop at level 2 wraps the pointers.
        cycle("lvl2_a", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        cycle("lvl2_b", 1'b1, 16'h5678, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle("stream", 1'b1, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        check("stream.level", 32'(bus.level), 32'd2);
        cycle("stream_drain0", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cycle("stream_drain1", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

`ifdef ADDER_RESULT_PARITY_EN
        // Even parity over {cout,sum} lands in the entry MSB.
        cycle("par0101", 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        check("par0101.msb", 32'(bus.out_data[DW-1]), 32'd0);
        cycle("par0001", 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
        check("par0001.msb", 32'(bus.out_data[DW-1]), 32'd1);
        cycle("par_drain", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`endif

        // Carry counter saturates, then clear wins over a simultaneous increment.
        for (int i = 0; i < CNT_MAX + 5; i++)
            cycle("sat", 1'b1, 16'(i), 1'b1, 1'b1, 1'b0);
        check("sat.cnt", 32'(bus.cout_cnt), 32'(CNT_MAX));
        cycle("clr_prio", 1'b1, 16'h7777, 1'b1, 1'b1, 1'b1);
        check("clr_prio.cnt", 32'(bus.cout_cnt), 32'd0);
        cycle("post_clr", 1'b1, 16'h8888, 1'b1, 1'b1, 1'b0);
        cycle("post_clr_drain", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at level 3 takes effect before the next edge.
        for (int i = 0; i < 3; i++)
            cycle("pre_rst", 1'b1, 16'(16'hC000 + i), 1'b1, 1'b0, 1'b0);
        check("pre_rst.level", 32'(bus.level), 32'd3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");

        // Traffic presented across a reset edge leaves no trace.
        bus.in_valid  = 1'b1;
        bus.sum       = 16'hDEAD;
        bus.cout      = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rst_edge");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #4;
        cycle("after_rst", 1'b1, 16'h4242, 1'b0, 1'b0, 1'b0);
        cycle("after_rst_pop", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001 Parameter WIDTH, default 16, sum width in bits; matches the 16-bit parallel-prefix adders.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, range 2 to 16.
REQ-003 Parameter CNT_W, default 8, width of the carry-out event counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  adder result on sum/cout is valid this cycle.
REQ-007 in_ready  output  1  FIFO can accept a result this cycle.
REQ-008 sum  input  WIDTH  sum output of the upstream adder.
REQ-009 cout  input  1  carry-out of the upstream adder.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_data  output  WIDTH+1  head entry as {cout,sum}; with ADDER_RESULT_PARITY_EN defined, width is WIDTH+2 as {parity,cout,sum}.
REQ-013 level  output  log2(DEPTH)+1  number of stored entries.
REQ-014 cout_cnt  output  CNT_W  count of accepted entries with cout=1.
REQ-015 cnt_clr  input  1  synchronous clear of cout_cnt.
REQ-016 ovf  output  1  sticky flag: in_valid was asserted while in_ready was low.

Function
REQ-017 Push occurs when in_valid and in_ready are both high on a rising edge; {cout,sum} is written at the write pointer.
REQ-018 Pop occurs when out_valid and out_ready are both high on a rising edge; the read pointer advances.
REQ-019 in_ready is high exactly when level < DEPTH, with no combinational path from out_ready.
REQ-020 out_valid is high exactly when level > 0; out_data is driven from storage at the read pointer, with no combinational path from sum or cout.
REQ-021 Latency: an entry pushed at edge N is presented on out_data/out_valid after edge N; there is no same-cycle bypass.
REQ-022 Push and pop at the same edge leave level unchanged and advance both pointers.
REQ-023 When full, an in_valid beat is dropped, FIFO contents are preserved, and ovf is set; a simultaneous pop still occurs.
REQ-024 When empty, out_ready is ignored and out_data holds its last value.
REQ-025 Pointers wrap modulo DEPTH; full and empty are derived from level.
REQ-026 On a push with cout=1, cout_cnt increments and saturates at 2^CNT_W-1.
REQ-027 cnt_clr forces cout_cnt to 0 and takes priority over a simultaneous increment.
REQ-028 ovf clears only on reset.

Reset
REQ-029 rst asserted: level=0, pointers=0, out_valid=0, in_ready=1, cout_cnt=0, ovf=0, out_data=0, all immediately and independent of clk.
REQ-030 rst asserted mid-operation discards all stored entries; pushes and pops at the reset edge have no effect.
REQ-031 Storage array contents need not be reset; out_data shall read 0 while empty after reset.

Configuration
REQ-032 Macro ADDER_RESULT_PARITY_EN, defined: each entry stores an even-parity bit computed over {cout,sum} at push time, presented as the MSB of out_data.
REQ-033 ADDER_RESULT_PARITY_EN undefined: there is no parity storage or logic, and out_data is WIDTH+1 bits.

Verification
REQ-034 Reset, then push sum=16'h1111 with cout=0 -> out_valid=1 after one edge, out_data=17'h01111, level=1.
REQ-035 Push the results of FFFF+FFFF cin=0 (sum=FFFE, cout=1) and FFFF+FFFF cin=1 (sum=FFFF, cout=1) -> pops return 17'h1FFFE then 17'h1FFFF in order, and cout_cnt=2.
REQ-036 Hold out_ready=0 and push 5 beats with DEPTH=4 -> in_ready=0 after the 4th push, the 5th beat is dropped, ovf=1, level=4, and the first 4 entries are read back intact.
REQ-037 At level=2, push and pop together for 10 cycles -> level stays 2, pointers wrap, and data order is preserved.
REQ-038 At level=3, assert rst asynchronously between edges -> out_valid=0, level=0, and in_ready=1 before the next edge.
REQ-039 With ADDER_RESULT_PARITY_EN defined, push sum=16'h0101 with cout=0 -> out_data MSB=0; push sum=16'h0001 with cout=0 -> out_data MSB=1.
